// File: rtl/pps_stream_splitter_pkg.sv
// rtl/pps_stream_splitter_pkg.sv - shared decoder constants and state encoding for the PPS splitter
package pps_stream_splitter_pkg;

    // Default geometry of the decoder input stream
    localparam int DATA_WIDTH_DEF = 256;
    localparam int FCNT_WIDTH_DEF = 16;

    // Picture parameter set size and its length in stream words
    localparam int PPS_BYTES = 128;
    localparam int PPS_WORDS = PPS_BYTES * 8 / DATA_WIDTH_DEF;

    // Splitter state encoding
    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_PPS  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    // Number of stream words that make up a PPS of the given byte size
    function automatic int words_of(input int bytes, input int width);
        return bytes * 8 / width;
    endfunction

endpackage

// File: rtl/pps_stream_splitter.sv
// rtl/pps_stream_splitter.sv - splits decoder input into a published PPS register and a slice-data stream
module pps_stream_splitter #(
    parameter int DATA_WIDTH = pps_stream_splitter_pkg::DATA_WIDTH_DEF,
    parameter int PPS_BYTES  = pps_stream_splitter_pkg::PPS_BYTES,
    parameter int FCNT_WIDTH = pps_stream_splitter_pkg::FCNT_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic                    in_eof,
    input  logic                    in_data_is_pps,
    output logic [PPS_BYTES*8-1:0]  pps_out,
    output logic                    pps_valid,
    output logic                    pps_err,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    output logic                    out_sof,
    output logic                    out_eof,
    output logic [FCNT_WIDTH-1:0]   frame_cnt
);
    import pps_stream_splitter_pkg::*;

    localparam int NWORDS   = words_of(PPS_BYTES, DATA_WIDTH);
    localparam int PPS_BITS = PPS_BYTES * 8;
    localparam int IDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [IDX_W-1:0]       wcnt;
    logic [DATA_WIDTH-1:0]  shadow [NWORDS];
    logic                   first_word;

    // Per-cycle actions decoded by the FSM
    logic                   take_first;
    logic                   take_next;
    logic                   publish;
    logic                   forward;
    logic                   set_err;

    // Shadow image including the word arriving this cycle, so the final
    // PPS word and the earlier ones are published in the same edge
    logic [PPS_BITS-1:0]    pps_assembled;

    // Next-state and action decode; nothing happens without in_valid
    always_comb begin
        state_nxt  = state;
        take_first = 1'b0;
        take_next  = 1'b0;
        publish    = 1'b0;
        forward    = 1'b0;
        set_err    = 1'b0;
        if (in_valid) begin
            case (state)
                S_WAIT: begin
                    if (in_data_is_pps && in_sof) begin
                        take_first = 1'b1;
                        state_nxt  = S_PPS;
                    end else begin
                        set_err    = 1'b1;
                    end
                end
                S_PPS: begin
                    if (!in_data_is_pps) begin
                        // Truncated PPS: abandon it and wait for a fresh sof
                        set_err    = 1'b1;
                        state_nxt  = S_WAIT;
                    end else if (in_sof) begin
                        // A new sof mid-capture restarts the capture from word 0
                        set_err    = 1'b1;
                        take_first = 1'b1;
                    end else begin
                        take_next  = 1'b1;
                        if (wcnt == LAST_IDX) begin
                            publish   = 1'b1;
                            state_nxt = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (!in_data_is_pps) begin
                        forward    = 1'b1;
                    end else if (in_sof) begin
                        take_first = 1'b1;
                        state_nxt  = S_PPS;
                    end else begin
                        // Stray PPS word without sof: drop it, keep forwarding slices
                        set_err    = 1'b1;
                    end
                end
                default: begin
                    state_nxt  = S_WAIT;
                end
            endcase
        end
    end

    // Merge the incoming word into the shadow image at the current index
    always_comb begin
        pps_assembled = '0;
        for (int i = 0; i < NWORDS; i++) begin
            pps_assembled[PPS_BITS-1-i*DATA_WIDTH -: DATA_WIDTH] =
                (IDX_W'(i) == wcnt) ? in_data : shadow[i];
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_WAIT;
        end else if (flush) begin
            state <= S_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Word counter and shadow capture, written by word index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
            for (int i = 0; i < NWORDS; i++) begin
                shadow[i] <= '0;
            end
        end else if (flush) begin
            wcnt <= '0;
            for (int i = 0; i < NWORDS; i++) begin
                shadow[i] <= '0;
            end
        end else if (take_first) begin
            shadow[0] <= in_data;
            wcnt      <= IDX_W'(1);
        end else if (take_next) begin
            shadow[wcnt] <= in_data;
            wcnt         <= publish ? '0 : wcnt + IDX_W'(1);
        end
    end

    // Published PPS: replaced only as a whole, so it never mixes two sets
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pps_out    <= '0;
            pps_valid  <= 1'b0;
            first_word <= 1'b0;
            pps_err    <= 1'b0;
        end else if (flush) begin
            pps_out    <= '0;
            pps_valid  <= 1'b0;
            first_word <= 1'b0;
            pps_err    <= 1'b0;
        end else begin
            if (publish) begin
                pps_out    <= pps_assembled;
                pps_valid  <= 1'b1;
            end else if (take_first) begin
                pps_valid  <= 1'b0;
            end
            if (publish) begin
                first_word <= 1'b1;
            end else if (forward) begin
                first_word <= 1'b0;
            end
            if (set_err) begin
                pps_err    <= 1'b1;
            end
        end
    end

    // Slice-data output stage and frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            frame_cnt <= '0;
        end else if (flush) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            out_valid <= forward;
            out_sof   <= forward & first_word;
            out_eof   <= forward & in_eof;
            if (forward) begin
                out_data <= in_data;
            end
            if (forward && in_eof) begin
                frame_cnt <= frame_cnt + FCNT_WIDTH'(1);
            end
        end
    end

endmodule
